// File: rtl/rv32i_instr_encoder.sv
// RV32I field-to-word encoder with immediate legality checks and a registered valid/ready
// output stage tagged with sequential IMEM word addresses. Optional macro: RV32I_ENC_ERRCNT_EN.
module rv32i_instr_encoder #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic              full_o
`ifdef RV32I_ENC_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt_o
`endif
);

    // One extra bit so the counter can hold IMEM_DEPTH itself when 2**ADDR_W == IMEM_DEPTH.
    localparam int unsigned     CntW     = ADDR_W + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(IMEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_count;
    logic [CntW-1:0]   w_cnt_inc;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic              w_hs;
    logic              w_accept;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_enc;
    logic              w_imm_ok;
    logic              w_err;
    logic              w_fits12;
    logic              w_fits13;
    logic              w_fits21;

    assign in_ready_o  = !full_o && !clear_i && (!r_valid || out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_hs        = r_valid && out_ready_i;
    assign w_cnt_inc   = r_count + 1'b1;
    // A word loaded in the same cycle as a handshake takes the post-increment address.
    assign w_next_addr = w_hs ? w_cnt_inc[ADDR_W-1:0] : r_count[ADDR_W-1:0];

    // Signed range checks expressed as "upper bits are a sign extension".
    assign w_fits12 = (imm_i[31:11] == {21{imm_i[11]}});
    assign w_fits13 = (imm_i[31:12] == {20{imm_i[12]}});
    assign w_fits21 = (imm_i[31:20] == {12{imm_i[20]}});

    always_comb begin
        w_enc    = '0;
        w_imm_ok = 1'b1;
        case (fmt_i)
            3'd0: w_enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            3'd1: begin
                w_enc    = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                w_imm_ok = w_fits12;
            end
            3'd2: begin
                w_enc    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                w_imm_ok = w_fits12;
            end
            3'd3: begin
                w_enc    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                w_imm_ok = w_fits13 && !imm_i[0];
            end
            3'd4: begin
                w_enc    = {imm_i[31:12], rd_i, opcode_i};
                w_imm_ok = (imm_i[11:0] == 12'h000);
            end
            3'd5: begin
                w_enc    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                w_imm_ok = w_fits21 && !imm_i[0];
            end
            default: w_imm_ok = 1'b0;
        endcase
    end

    assign w_err = (opcode_i[1:0] != 2'b11) || !w_imm_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = StIdle;
        end else if (w_hs && (r_state != StFull)) begin
            w_state_next = (w_cnt_inc == DepthCnt) ? StFull : StFill;
        end
    end

    always_comb begin
        full_o = (r_state == StFull);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs && (r_state != StFull)) begin
                r_count <= w_cnt_inc;
            end
            if (w_accept) begin
                r_valid <= 1'b1;
                r_instr <= w_err ? 32'h0000_0000 : w_enc;
                r_addr  <= w_next_addr;
                r_err   <= w_err;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_valid;
    assign instr_o     = r_instr;
    assign addr_o      = r_addr;
    assign err_o       = r_err;

`ifdef RV32I_ENC_ERRCNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_err_cnt <= '0;
        end else if (w_hs && r_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: directed test-plan vectors plus randomized traffic
// checked against an arithmetic reference model.
module tb_rv32i_instr_encoder;

    localparam int unsigned Depth = 4;
    localparam int unsigned AddrW = 2;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             clear_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [2:0]       fmt_i = '0;
    logic [6:0]       opcode_i = '0;
    logic [4:0]       rd_i = '0;
    logic [4:0]       rs1_i = '0;
    logic [4:0]       rs2_i = '0;
    logic [2:0]       funct3_i = '0;
    logic [6:0]       funct7_i = '0;
    logic [31:0]      imm_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [31:0]      instr_o;
    logic [AddrW-1:0] addr_o;
    logic             err_o;
    logic             full_o;
`ifdef RV32I_ENC_ERRCNT_EN
    logic [15:0]      err_cnt_o;
`endif

    rv32i_instr_encoder #(
        .IMEM_DEPTH (Depth),
        .ADDR_W     (AddrW)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fmt_i       (fmt_i),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .addr_o      (addr_o),
        .err_o       (err_o),
        .full_o      (full_o)
`ifdef RV32I_ENC_ERRCNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          hs_cnt = 0;
    logic        mon_en = 1'b0;
    logic        post_flush = 1'b0;
    logic        post_rst = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] sv_instr;
    logic [31:0] sv_addr;
    logic        sv_err;
    // Directed vectors may supply a hand-computed expected word instead of the model's.
    logic        ov_en = 1'b0;
    logic [31:0] ov_instr = '0;
    logic        ov_err = 1'b0;
    int unsigned exp_ecnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference encoder: bit fields placed by shifting, ranges checked as signed integers.
    function automatic logic [32:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] imm);
        int          s;
        logic [31:0] w;
        logic [31:0] base;
        bit          bad;
        s    = $signed(imm);
        bad  = (op % 4) != 3;
        w    = '0;
        base = (32'(f3) << 12) | 32'(op);
        case (f)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | base;
            3'd1: begin
                bad = bad || s < -2048 || s > 2047;
                w   = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | base;
            end
            3'd2: begin
                bad = bad || s < -2048 || s > 2047;
                w   = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | ((imm & 32'h1F) << 7) | base;
            end
            3'd3: begin
                bad = bad || s < -4096 || s > 4094 || (imm & 1) != 0;
                w   = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (32'(rs2) << 20) | (32'(rs1) << 15) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | base;
            end
            3'd4: begin
                bad = bad || (imm & 32'hFFF) != 0;
                w   = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
            end
            3'd5: begin
                bad = bad || s < -1048576 || s > 1048574 || (imm & 1) != 0;
                w   = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'(op);
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = '0;
        return {bad, w};
    endfunction

    // Monitor / scoreboard: everything observed mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            exp_t e;
            logic [32:0] r;
            logic exp_valid;
            logic exp_full;
            exp_valid = (sb_q.size() != 0);
            exp_full  = (hs_cnt >= Depth);
            chk("out_valid", 32'(out_valid_o), 32'(exp_valid));
            chk("full", 32'(full_o), 32'(exp_full));
            chk("in_ready", 32'(in_ready_o),
                32'(!exp_full && !clear_i && (!exp_valid || out_ready_i)));
            if (post_flush) chk("addr_after_flush", 32'(addr_o), 32'd0);
            if (post_rst) begin
                chk("instr_after_rst", instr_o, 32'd0);
                chk("err_after_rst", 32'(err_o), 32'd0);
            end
            if (stall_prev) begin
                chk("stall_instr", instr_o, sv_instr);
                chk("stall_addr", 32'(addr_o), sv_addr);
                chk("stall_err", 32'(err_o), 32'(sv_err));
            end
`ifdef RV32I_ENC_ERRCNT_EN
            chk("err_cnt", 32'(err_cnt_o), exp_ecnt);
`endif
            if (rst_i || clear_i) begin
                sb_q.delete();
                acc_cnt    = 0;
                hs_cnt     = 0;
                exp_ecnt   = 0;
                post_flush = 1'b1;
                post_rst   = rst_i;
                stall_prev = 1'b0;
            end else begin
                post_flush = 1'b0;
                post_rst   = 1'b0;
                if (out_valid_o && out_ready_i) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("instr", instr_o, e.instr);
                        chk("addr", 32'(addr_o), e.addr);
                        chk("err", 32'(err_o), 32'(e.err));
                        if (e.err && exp_ecnt != 32'hFFFF) exp_ecnt++;
                    end
                    hs_cnt++;
                end
                stall_prev = out_valid_o && !out_ready_i;
                sv_instr   = instr_o;
                sv_addr    = 32'(addr_o);
                sv_err     = err_o;
                if (in_valid_i && in_ready_o) begin
                    r = ref_word(fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
                    e.instr = ov_en ? ov_instr : r[31:0];
                    e.err   = ov_en ? ov_err : r[32];
                    e.addr  = acc_cnt % (1 << AddrW);
                    sb_q.push_back(e);
                    acc_cnt++;
                end
            end
        end
    end

    task automatic pulse_clear();
        @(posedge clk_i); #1;
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic use_exp,
                        input logic [31:0] ei, input logic ee);
        bit got = 0;
        if (acc_cnt >= Depth) pulse_clear();
        @(posedge clk_i); #1;
        fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        ov_en = use_exp; ov_instr = ei; ov_err = ee;
        in_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                got = 1;
                break;
            end
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        ov_en = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] gen_imm(input logic [2:0] f);
        int lo;
        int hi;
        int mode;
        int pick;
        mode = int'($urandom_range(0, 3));
        case (f)
            3'd1, 3'd2: begin lo = -2048;    hi = 2047;    end
            3'd3:       begin lo = -4096;    hi = 4094;    end
            3'd5:       begin lo = -1048576; hi = 1048574; end
            default:    begin lo = 0;        hi = 0;       end
        endcase
        if (f == 3'd4) return (mode == 0) ? $urandom() : ($urandom() & 32'hFFFF_F000);
        if (f == 3'd0 || f > 3'd5 || mode == 2) return $urandom();
        if (mode == 1) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       return 32'(lo);
                1:       return 32'(hi);
                2:       return 32'(lo - 1);
                default: return 32'(hi + 1);
            endcase
        end
        pick = lo + int'($urandom_range(0, 32'(hi - lo)));
        if (f == 3'd3 || f == 3'd5) pick = pick & ~1;
        return 32'(pick);
    endfunction

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_i);
        chk("reset_instr", instr_o, 32'd0);
        chk("reset_addr", 32'(addr_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);

        out_ready_i = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002081B3, 0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00093, 0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h0, 1);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1, 32'h00208463, 0);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1, 32'h0, 1);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7, 0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1, 32'h0, 1);

        // Backpressure: second bundle waits while the first word is stalled.
        pulse_clear();
        out_ready_i = 1'b0;
        send(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'd0, 0, 32'h0, 0);
        fork
            send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd100, 0, 32'h0, 0);
            begin
                repeat (4) @(posedge clk_i);
                #2;
                out_ready_i = 1'b1;
            end
        join
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'h0, 0);
        send(3'd2, 7'h23, 5'd0, 5'd4, 5'd5, 3'd2, 7'd0, 32'hFFFF_F800, 0, 32'h0, 0);
        repeat (3) @(posedge clk_i);

        // Fill, then flush and restart at address 0.
        pulse_clear();
        for (int i = 0; i < Depth; i++) begin
            send(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 0, 32'h0, 0);
        end
        repeat (3) @(posedge clk_i);
        pulse_clear();
        send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 0, 32'h0, 0);
        repeat (2) @(posedge clk_i);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i); #1;
            rst_i       = ($urandom_range(0, 299) == 0);
            clear_i     = full_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            in_valid_i  = (acc_cnt < Depth) && ($urandom_range(0, 3) != 0);
            fmt_i       = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                      : 3'($urandom_range(0, 5));
            opcode_i    = 7'($urandom());
            if ($urandom_range(0, 7) != 0) opcode_i[1:0] = 2'b11;
            rd_i        = 5'($urandom());
            rs1_i       = 5'($urandom());
            rs2_i       = 5'($urandom());
            funct3_i    = 3'($urandom());
            funct7_i    = 7'($urandom());
            imm_i       = gen_imm(fmt_i);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the RV32I instruction decode path: packs instruction fields (format, opcode, registers, funct3/funct7, immediate) into a 32-bit RV32I instruction word.
- Range-checks the immediate for the chosen format.
- Emits each word through a registered valid/ready output stage, tagged with a sequential instruction-memory word address.
- Sits between the test/program-generation front end and the instruction memory write port.

Parameters:
- IMEM_DEPTH, 1024, number of instruction-memory words that can be filled before full.
- ADDR_W, 10, width of the word address; must satisfy 2**ADDR_W >= IMEM_DEPTH.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous flush: resets address counter and output stage.
- in_valid_i  input  1  field bundle valid.
- in_ready_o  output  1  encoder can accept a bundle this cycle.
- fmt_i  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode_i  input  7  opcode field.
- rd_i, rs1_i, rs2_i  input  5 each  register indices.
- funct3_i  input  3  funct3 field.
- funct7_i  input  7  funct7 field.
- imm_i  input  32  full signed immediate value (byte offset for B/J; full 32-bit value for U).
- out_valid_o  output  1  encoded word valid.
- out_ready_i  input  1  consumer accepts the word.
- instr_o  output  32  encoded instruction.
- addr_o  output  ADDR_W  word address of instr_o.
- err_o  output  1  the bundle in the output stage failed legality checks.
- full_o  output  1  IMEM_DEPTH words have been emitted.

Behaviour:
- Reset (rst_i=1): out_valid_o=0, instr_o=0, addr_o=0, err_o=0, full_o=0, address counter=0, state IDLE.
- State machine (on address counter):
  - IDLE (count=0) -> FILL on first output handshake.
  - FILL -> FULL when count reaches IMEM_DEPTH.
  - FULL -> IDLE only on clear_i or rst_i.
- in_ready_o = !full_o && !clear_i && (!out_valid_o || out_ready_i).
- Input accept = in_valid_i && in_ready_o.
- Latency: an accepted bundle appears on instr_o/addr_o/err_o with out_valid_o=1 the next cycle. Single-entry output register, full throughput when out_ready_i=1.
- While out_valid_o=1 && out_ready_i=0: instr_o, addr_o and err_o hold stable and no new bundle is accepted.
- Output handshake (out_valid_o && out_ready_i):
  - count increments by 1; addr_o for the next word = count.
  - full_o asserts in the cycle after the handshake that brings count to IMEM_DEPTH. No wrap-around.
- A simultaneous output handshake and input accept is legal: the register is reloaded and out_valid_o stays 1.
- Encoding (RISC-V base formats):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Fields unused by a format are ignored.
- Legality checks; a failure sets err_o=1 and forces instr_o=32'h00000000:
  - opcode_i[1:0] != 2'b11.
  - fmt_i is 6 or 7.
  - I/S: imm_i outside [-2048, 2047].
  - B: imm_i outside [-4096, 4094], or imm_i[0]=1.
  - U: imm_i[11:0] != 0.
  - J: imm_i outside [-1048576, 1048574], or imm_i[0]=1.
  - R: no immediate check.
- Erroneous words still handshake and consume an address.
- clear_i: next cycle out_valid_o=0, count=0, addr_o=0, full_o=0, state IDLE. Any pending output word is discarded. clear_i has priority over a simultaneous handshake.
- rst_i mid-operation: identical to clear_i plus all outputs at their reset values.

Optional Feature:
- Macro RV32I_ENC_ERRCNT_EN.
- Defined:
  - Adds output err_cnt_o (16 bits).
  - Increments by 1 on each output handshake with err_o=1.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i or clear_i.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- R, op=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0, out_ready_i=1 -> next cycle instr_o=0x002081B3, addr_o=0, err_o=0.
- I, op=0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> instr_o=0xFFF00093. Same with imm=2048 -> err_o=1, instr_o=0.
- B, op=0x63, rs1=1, rs2=2, f3=0, imm=8 -> instr_o=0x00208463. Same with imm=7 -> err_o=1, instr_o=0, addr_o still advances.
- U, op=0x37, rd=5, imm=0x12345000 -> instr_o=0x123452B7. imm=0x12345001 -> err_o=1.
- Backpressure: hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, instr_o/addr_o stable, count unchanged. Release -> one word per cycle.
- IMEM_DEPTH=4: push 4 words -> addr_o 0..3, full_o=1, in_ready_o=0. Pulse clear_i -> full_o=0, next word at addr_o=0.
